// File: rtl/oled_iic_tx.sv
// Byte-level I2C write transmitter for the OLED sequencer.
// Each request sends START, 8'h78, control byte, data byte, STOP, then pulses iic_done.
module oled_iic_tx #(
    parameter int unsigned DIV_Q      = 63,
    parameter logic [6:0]  SLAVE_ADDR = 7'h3C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iic_start,
    input  logic [7:0] iic_data,
    input  logic       dc,
    output logic       iic_done,
    output logic       busy,
    output logic       nack,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam logic [7:0] QMax = 8'(DIV_Q - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StBit,
        StStop,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  qcnt_q, qcnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [23:0] shift_q, shift_d;
    logic        nack_q, nack_d;
    logic        counting, qtick, ack_slot;

    always_comb begin
        counting = (state_q == StStart) || (state_q == StBit) || (state_q == StStop);
        qtick    = counting && (qcnt_q == QMax);
        ack_slot = (bit_q == 4'd8);

        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        nack_d  = nack_q;
        qcnt_d  = counting ? (qtick ? 8'd0 : qcnt_q + 8'd1) : 8'd0;
        scl     = 1'b1;
        sda_oe  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (iic_start) begin
                    shift_d = {SLAVE_ADDR, 1'b0, (dc ? 8'h40 : 8'h00), iic_data};
                    nack_d  = 1'b0;
                    bit_d   = 4'd0;
                    byte_d  = 2'd0;
                    phase_d = 2'd0;
                    state_d = StLoad;
                end
            end
            // One-cycle hold so iic_done lands at accept edge + 1 + 112 quarters.
            StLoad: state_d = StStart;
            StStart: begin
                sda_oe = 1'b1;
                if (qtick) begin
                    phase_d = 2'd0;
                    state_d = StBit;
                end
            end
            StBit: begin
                scl    = phase_q[1];
                sda_oe = ack_slot ? 1'b0 : ~shift_q[23];
                if (qtick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd2 && ack_slot && sda_i) begin
                        nack_d = 1'b1;
                    end
                    if (phase_q == 2'd3) begin
                        if (ack_slot) begin
                            bit_d = 4'd0;
                            if (byte_q == 2'd2) begin
                                state_d = StStop;
                            end else begin
                                byte_d = byte_q + 2'd1;
                            end
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            shift_d = {shift_q[22:0], 1'b0};
                        end
                    end
                end
            end
            StStop: begin
                scl    = (phase_q != 2'd0);
                sda_oe = (phase_q != 2'd2);
                if (qtick) begin
                    if (phase_q == 2'd2) begin
                        state_d = StDone;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            qcnt_q  <= 8'd0;
            phase_q <= 2'd0;
            bit_q   <= 4'd0;
            byte_q  <= 2'd0;
            shift_q <= 24'd0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            nack_q  <= nack_d;
        end
    end

    assign iic_done = (state_q == StDone);
    assign busy     = (state_q != StIdle);
    assign nack     = nack_q;

endmodule

// File: tb/tb_oled_iic_tx.sv
// Scoreboard bench for oled_iic_tx: a bus decoder/slave pops expected bytes,
// a done monitor pops expected completion cycle and nack.
module tb_oled_iic_tx;

    localparam int unsigned Q    = 4;
    localparam int          TXN  = 1 + 112 * Q;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iic_start = 1'b0;
    logic [7:0] iic_data = 8'h00;
    logic       dc = 1'b0;
    logic       iic_done, busy, nack, scl, sda_oe, sda_i;
    logic       slave_pull = 1'b0;
    logic [2:0] nack_mask = 3'b000;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] exp_bytes[$];
    int         exp_done_cyc[$];
    bit         exp_nack[$];

    oled_iic_tx #(.DIV_Q(Q), .SLAVE_ADDR(7'h3C)) dut (
        .clk       (clk),
        .rst       (rst),
        .iic_start (iic_start),
        .iic_data  (iic_data),
        .dc        (dc),
        .iic_done  (iic_done),
        .busy      (busy),
        .nack      (nack),
        .scl       (scl),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i)
    );

    assign sda_i = ~(sda_oe | slave_pull);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus decoder, bench slave and done monitor, sampled 1 time unit after each edge.
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_done = 1'b0, stop_seen = 1'b0;
    logic [7:0] shreg = 8'h00;
    int         bitn = 0, byte_idx = 0, nbytes = 0, busy_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            bitn = 0; byte_idx = 0; busy_cnt = 0; slave_pull = 1'b0;
            prev_done = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
        end else begin
            if (busy) busy_cnt++;
            if (prev_scl && scl && prev_sda && !sda_i) begin
                bitn = 0; byte_idx = 0; nbytes = 0; stop_seen = 1'b0;
            end else if (prev_scl && scl && !prev_sda && sda_i) begin
                stop_seen = 1'b1;
            end else if (!prev_scl && scl) begin
                if (bitn < 8) shreg = {shreg[6:0], sda_i};
                bitn++;
                if (bitn == 9) begin
                    if (exp_bytes.size() == 0) check("unexpected_byte", int'(shreg), -1);
                    else check("bus_byte", int'(shreg), int'(exp_bytes.pop_front()));
                    nbytes++; byte_idx++; bitn = 0;
                end
            end else if (prev_scl && !scl) begin
                slave_pull = (bitn == 8) && (byte_idx < 3) && !nack_mask[byte_idx];
            end
            if (prev_done) check("done_width", int'(iic_done), 0);
            if (iic_done) begin
                if (exp_done_cyc.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("done_cycle", cyc, exp_done_cyc.pop_front());
                    check("nack_at_done", int'(nack), int'(exp_nack.pop_front()));
                    check("bytes_in_txn", nbytes, 3);
                    check("stop_seen", int'(stop_seen), 1);
                    check("busy_cycles", busy_cnt, TXN + 1);
                end
                busy_cnt = 0;
            end
            prev_done = iic_done;
        end
        prev_scl = scl;
        prev_sda = sda_i;
    end

    // Called at a negedge; start is sampled on the following posedge.
    task automatic send(input logic [7:0] d, input bit dcb, input bit nk, input bit expect_it);
        iic_start = 1'b1;
        iic_data  = d;
        dc        = dcb;
        if (expect_it) begin
            exp_bytes.push_back(8'h78);
            exp_bytes.push_back(dcb ? 8'h40 : 8'h00);
            exp_bytes.push_back(d);
            exp_done_cyc.push_back(cyc + 1 + TXN);
            exp_nack.push_back(nk);
        end
        @(negedge clk);
        iic_start = 1'b0;
        iic_data  = 8'($urandom);
        dc        = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!iic_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("done_timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_scl", int'(scl), 1);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_done", int'(iic_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_nack", int'(nack), 0);
        rst = 1'b1;
        @(negedge clk);

        send(8'hAE, 1'b0, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        send(8'hFF, 1'b1, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        nack_mask = 3'b001;
        send(8'h3C, 1'b0, 1'b1, 1'b1);
        wait_done();
        check("nack_after_done", int'(nack), 1);
        @(negedge clk);
        nack_mask = 3'b000;
        send(8'h5A, 1'b1, 1'b0, 1'b1);
        check("nack_cleared", int'(nack), 0);
        wait_done();
        @(negedge clk);

        send(8'h11, 1'b0, 1'b0, 1'b1);
        repeat (48) @(negedge clk);
        send(8'h55, 1'b0, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);
        send(8'h55, 1'b0, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        // Abort during the control byte: only the address byte reaches the bus.
        exp_bytes.push_back(8'h78);
        send(8'h12, 1'b0, 1'b0, 1'b0);
        repeat (170) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_scl", int'(scl), 1);
        check("abort_sda_oe", int'(sda_oe), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(iic_done), 0);
        rst = 1'b1;
        repeat (600) @(negedge clk);
        check("abort_bytes_left", exp_bytes.size(), 0);

        send(8'hC3, 1'b1, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        for (int i = 0; i < 32; i++) begin
            send(8'(i * 7 + 1), 1'(i), 1'b0, 1'b1);
            wait_done();
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("pending_dones", exp_done_cyc.size(), 0);
        check("pending_bytes", exp_bytes.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
